// File: rtl/m_wbfifo_responder_pkg.sv
// Shared definitions for the Wishbone FIFO responder: FSM states, register
// select values, status/control bit positions and the byte-lane mask helper.
package m_wbfifo_responder_pkg;

    // Transfer FSM states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_e;

    // Register select (ADR_I).
    localparam logic ADR_DATA   = 1'b0;
    localparam logic ADR_STATUS = 1'b1;

    // STATUS read bit positions.
    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVF   = 2;
    localparam int ST_UDF   = 3;
    localparam int ST_CNT   = 8;

    // STATUS write control bits (honoured only when SEL_I[0] is set).
    localparam int CTL_CLR   = 0;
    localparam int CTL_FLUSH = 1;

    // Force unselected byte lanes of a write word to zero.
    function automatic logic [31:0] mask_lanes(input logic [3:0] sel, input logic [31:0] dat);
        logic [31:0] res;
        res = '0;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) res[8*i +: 8] = dat[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/m_wbfifo_responder_if.sv
// Wishbone classic bus bundle between the core's data bus and the FIFO responder.
interface m_wbfifo_responder_if;
    logic        STB_I;
    logic        WE_I;
    logic        ADR_I;
    logic [3:0]  SEL_I;
    logic [31:0] DAT_I;
    logic        ACK_O;
    logic [31:0] DAT_O;

    modport master (
        output STB_I, WE_I, ADR_I, SEL_I, DAT_I,
        input  ACK_O, DAT_O
    );

    modport slave (
        input  STB_I, WE_I, ADR_I, SEL_I, DAT_I,
        output ACK_O, DAT_O
    );
endinterface

// File: rtl/m_wbfifo_mem.sv
// FIFO storage: synchronous write, combinational read, 2**DEPTHLOG2 words.
module m_wbfifo_mem #(
    parameter int DEPTHLOG2 = 4,
    parameter int WIDTH     = 32
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [DEPTHLOG2-1:0] waddr_i,
    input  logic [WIDTH-1:0]     wdata_i,
    input  logic [DEPTHLOG2-1:0] raddr_i,
    output logic [WIDTH-1:0]     rdata_o
);

    logic [WIDTH-1:0] mem_q [1 << DEPTHLOG2];

    // Write port.
    // NOTE: storage has no reset; stale words are unreachable because the pointers are reset.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/m_wbfifo_responder.sv
// Wishbone classic responder: 32-bit FIFO mailbox plus STATUS/control register,
// with a programmable number of wait states before each acknowledge.
module m_wbfifo_responder
    import m_wbfifo_responder_pkg::*;
#(
    parameter int DEPTHLOG2  = 4,
    parameter int WAITSTATES = 1
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    m_wbfifo_responder_if.slave   wb,
    output logic                  irq
);

    localparam int PW = DEPTHLOG2 + 1;

    state_e          state_q, state_d;
    logic [3:0]      waitcnt_q, waitcnt_d;
    logic            capture;

    logic            we_q, adr_q;
    logic [3:0]      sel_q;
    logic [31:0]     dat_q;

    logic [PW-1:0]   wrptr_q, wrptr_d, rdptr_q, rdptr_d;
    logic            ovf_q, ovf_d, udf_q, udf_d;
    logic            irq_q;

    logic            empty, full;
    logic [PW-1:0]   count;
    logic            mem_we;
    logic [31:0]     head_word, push_word, status_word;
    logic            ack;
    logic [31:0]     dat_o;

    assign empty = (wrptr_q == rdptr_q);
    assign full  = (wrptr_q[PW-1] != rdptr_q[PW-1]) &&
                   (wrptr_q[PW-2:0] == rdptr_q[PW-2:0]);
    assign count = wrptr_q - rdptr_q;

    assign push_word = mask_lanes(sel_q, dat_q);

    m_wbfifo_mem #(
        .DEPTHLOG2 (DEPTHLOG2),
        .WIDTH     (32)
    ) u_mem (
        .clk_i   (CLK_I),
        .we_i    (mem_we),
        .waddr_i (wrptr_q[DEPTHLOG2-1:0]),
        .wdata_i (push_word),
        .raddr_i (rdptr_q[DEPTHLOG2-1:0]),
        .rdata_o (head_word)
    );

    // Assemble the STATUS read word from the live FIFO state and sticky flags.
    always_comb begin
        status_word                 = '0;
        status_word[ST_EMPTY]       = empty;
        status_word[ST_FULL]        = full;
        status_word[ST_OVF]         = ovf_q;
        status_word[ST_UDF]         = udf_q;
        status_word[ST_CNT +: PW]   = count;
    end

    // Transfer FSM next state: wait-state countdown and abort on dropped strobe.
    // NOTE: combinational blocks use blocking '=' and assign every output first, so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        waitcnt_d = waitcnt_q;
        capture   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (wb.STB_I) begin
                    capture   = 1'b1;
                    waitcnt_d = 4'(WAITSTATES);
                    state_d   = (WAITSTATES == 0) ? S_ACK : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!wb.STB_I) begin
                    state_d = S_IDLE;
                end else if (waitcnt_q <= 4'd1) begin
                    state_d = S_ACK;
                end else begin
                    waitcnt_d = waitcnt_q - 4'd1;
                end
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ACK-cycle side effects: push/pop, sticky flags, control writes, read data.
    always_comb begin
        wrptr_d = wrptr_q;
        rdptr_d = rdptr_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        mem_we  = 1'b0;
        ack     = 1'b0;
        dat_o   = '0;
        if (state_q == S_ACK) begin
            ack = 1'b1;
            if (adr_q == ADR_DATA) begin
                if (we_q) begin
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        mem_we  = 1'b1;
                        wrptr_d = wrptr_q + 1'b1;
                    end
                end else begin
                    if (empty) begin
                        udf_d = 1'b1;
                    end else begin
                        dat_o   = head_word;
                        rdptr_d = rdptr_q + 1'b1;
                    end
                end
            end else begin
                if (we_q) begin
                    if (sel_q[0]) begin
                        if (dat_q[CTL_CLR]) begin
                            ovf_d = 1'b0;
                            udf_d = 1'b0;
                        end
                        if (dat_q[CTL_FLUSH]) begin
                            wrptr_d = '0;
                            rdptr_d = '0;
                        end
                    end
                end else begin
                    dat_o = status_word;
                end
            end
        end
    end

    assign wb.ACK_O = ack;
    assign wb.DAT_O = dat_o;
    assign irq      = irq_q;

    // State, captured request, pointers, flags and registered interrupt.
    // NOTE: sequential blocks use non-blocking '<=' so all registers update from pre-edge values.
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q   <= S_IDLE;
            waitcnt_q <= '0;
            we_q      <= 1'b0;
            adr_q     <= 1'b0;
            sel_q     <= '0;
            dat_q     <= '0;
            wrptr_q   <= '0;
            rdptr_q   <= '0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            waitcnt_q <= waitcnt_d;
            if (capture) begin
                we_q  <= wb.WE_I;
                adr_q <= wb.ADR_I;
                sel_q <= wb.SEL_I;
                dat_q <= wb.DAT_I;
            end
            wrptr_q   <= wrptr_d;
            rdptr_q   <= rdptr_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            irq_q     <= ~empty;
        end
    end

endmodule

// File: tb/tb_m_wbfifo_responder.sv
// Directed bench for m_wbfifo_responder: three instances with WAITSTATES 1, 3 and 0.
module tb_m_wbfifo_responder;
    import m_wbfifo_responder_pkg::*;

    localparam int D_WS1 = 0;
    localparam int D_WS3 = 1;
    localparam int D_WS0 = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  stb = '0;
    logic        we  = 1'b0;
    logic        adr = 1'b0;
    logic [3:0]  sel = '0;
    logic [31:0] dat = '0;
    logic        irq_ws1, irq_ws3, irq_ws0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    m_wbfifo_responder_if bus_ws1 ();
    m_wbfifo_responder_if bus_ws3 ();
    m_wbfifo_responder_if bus_ws0 ();

    assign bus_ws1.STB_I = stb[D_WS1];
    assign bus_ws3.STB_I = stb[D_WS3];
    assign bus_ws0.STB_I = stb[D_WS0];
    assign bus_ws1.WE_I  = we;
    assign bus_ws3.WE_I  = we;
    assign bus_ws0.WE_I  = we;
    assign bus_ws1.ADR_I = adr;
    assign bus_ws3.ADR_I = adr;
    assign bus_ws0.ADR_I = adr;
    assign bus_ws1.SEL_I = sel;
    assign bus_ws3.SEL_I = sel;
    assign bus_ws0.SEL_I = sel;
    assign bus_ws1.DAT_I = dat;
    assign bus_ws3.DAT_I = dat;
    assign bus_ws0.DAT_I = dat;

    m_wbfifo_responder #(.DEPTHLOG2(4), .WAITSTATES(1)) u_ws1 (
        .CLK_I (clk), .RST_I (rst), .wb (bus_ws1.slave), .irq (irq_ws1));
    m_wbfifo_responder #(.DEPTHLOG2(4), .WAITSTATES(3)) u_ws3 (
        .CLK_I (clk), .RST_I (rst), .wb (bus_ws3.slave), .irq (irq_ws3));
    m_wbfifo_responder #(.DEPTHLOG2(4), .WAITSTATES(0)) u_ws0 (
        .CLK_I (clk), .RST_I (rst), .wb (bus_ws0.slave), .irq (irq_ws0));

    function automatic logic ack_of(input int d);
        case (d)
            D_WS1:   return bus_ws1.ACK_O;
            D_WS3:   return bus_ws3.ACK_O;
            default: return bus_ws0.ACK_O;
        endcase
    endfunction

    function automatic logic [31:0] rdat_of(input int d);
        case (d)
            D_WS1:   return bus_ws1.DAT_O;
            D_WS3:   return bus_ws3.DAT_O;
            default: return bus_ws0.DAT_O;
        endcase
    endfunction

    function automatic logic irq_of(input int d);
        case (d)
            D_WS1:   return irq_ws1;
            D_WS3:   return irq_ws3;
            default: return irq_ws0;
        endcase
    endfunction

    // One complete transfer; lat = clock edges from strobe sample to ACK visible.
    task automatic xfer(input int d, input logic w, input logic a, input logic [3:0] s,
                        input logic [31:0] v, output logic [31:0] rdata, output int lat);
        rdata = '0;
        lat   = 0;
        @(posedge clk); #1;
        we = w; adr = a; sel = s; dat = v;
        stb[d] = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            if (ack_of(d)) begin
                lat   = n;
                rdata = rdat_of(d);
                break;
            end
        end
        stb[d] = 1'b0;
        if (lat == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL xfer_timeout dut=%0d: no ACK_O within 40 cycles", d);
        end
    endtask

    task automatic push(input int d, input logic [31:0] v, input logic [3:0] s);
        logic [31:0] r; int l;
        xfer(d, 1'b1, ADR_DATA, s, v, r, l);
    endtask

    task automatic pop(input int d, output logic [31:0] r);
        int l;
        xfer(d, 1'b0, ADR_DATA, 4'hF, 32'h0, r, l);
    endtask

    task automatic rd_status(input int d, output logic [31:0] r);
        int l;
        xfer(d, 1'b0, ADR_STATUS, 4'hF, 32'h0, r, l);
    endtask

    task automatic wr_ctl(input int d, input logic [31:0] v, input logic [3:0] s);
        logic [31:0] r; int l;
        xfer(d, 1'b1, ADR_STATUS, s, v, r, l);
    endtask

    task automatic test_reset();
        logic [31:0] r; int l;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus_ws1.ACK_O !== 1'b0) begin n_errors++; $display("FAIL reset_ack got=%b exp=0", bus_ws1.ACK_O); end
        n_checks++;
        if (bus_ws1.DAT_O !== 32'h0) begin n_errors++; $display("FAIL reset_dat got=%h exp=00000000", bus_ws1.DAT_O); end
        n_checks++;
        if (irq_ws1 !== 1'b0) begin n_errors++; $display("FAIL reset_irq got=%b exp=0", irq_ws1); end
        rst = 1'b0;
        xfer(D_WS1, 1'b0, ADR_STATUS, 4'hF, 32'h0, r, l);
        n_checks++;
        if (l !== 2) begin n_errors++; $display("FAIL reset_status_latency got=%0d exp=2", l); end
        n_checks++;
        if (r !== 32'h0000_0001) begin n_errors++; $display("FAIL reset_status got=%h exp=00000001", r); end
        n_checks++;
        if (irq_ws1 !== 1'b0) begin n_errors++; $display("FAIL reset_status_irq got=%b exp=0", irq_ws1); end
    endtask

    task automatic test_push_pop();
        logic [31:0] r;
        push(D_WS1, 32'hDEAD_BEEF, 4'b1111);
        push(D_WS1, 32'h1234_5678, 4'b0101);
        rd_status(D_WS1, r);
        n_checks++;
        if (r !== 32'h0000_0200) begin n_errors++; $display("FAIL pp_status got=%h exp=00000200", r); end
        n_checks++;
        if (irq_ws1 !== 1'b1) begin n_errors++; $display("FAIL pp_irq_high got=%b exp=1", irq_ws1); end
        pop(D_WS1, r);
        n_checks++;
        if (r !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL pp_pop1 got=%h exp=deadbeef", r); end
        pop(D_WS1, r);
        n_checks++;
        if (r !== 32'h0034_0078) begin n_errors++; $display("FAIL pp_pop2 got=%h exp=00340078", r); end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (irq_ws1 !== 1'b0) begin n_errors++; $display("FAIL pp_irq_low got=%b exp=0", irq_ws1); end
    endtask

    task automatic test_overflow();
        logic [31:0] r;
        for (int i = 1; i <= 17; i++) push(D_WS1, 32'(i), 4'hF);
        rd_status(D_WS1, r);
        n_checks++;
        if (r !== 32'h0000_1006) begin n_errors++; $display("FAIL ovf_status got=%h exp=00001006", r); end
        for (int i = 1; i <= 16; i++) begin
            pop(D_WS1, r);
            n_checks++;
            if (r !== 32'(i)) begin n_errors++; $display("FAIL ovf_pop%0d got=%h exp=%h", i, r, 32'(i)); end
        end
        rd_status(D_WS1, r);
        n_checks++;
        if (r !== 32'h0000_0005) begin n_errors++; $display("FAIL ovf_drained got=%h exp=00000005", r); end
        wr_ctl(D_WS1, 32'h2, 4'hF);
        rd_status(D_WS1, r);
        n_checks++;
        if (r !== 32'h0000_0005) begin n_errors++; $display("FAIL ovf_flush_keeps got=%h exp=00000005", r); end
        wr_ctl(D_WS1, 32'h1, 4'hF);
        rd_status(D_WS1, r);
        n_checks++;
        if (r !== 32'h0000_0001) begin n_errors++; $display("FAIL ovf_cleared got=%h exp=00000001", r); end
    endtask

    task automatic test_underflow();
        logic [31:0] r;
        pop(D_WS1, r);
        n_checks++;
        if (r !== 32'h0) begin n_errors++; $display("FAIL udf_pop got=%h exp=00000000", r); end
        rd_status(D_WS1, r);
        n_checks++;
        if (r !== 32'h0000_0009) begin n_errors++; $display("FAIL udf_status got=%h exp=00000009", r); end
        wr_ctl(D_WS1, 32'h1, 4'b0010);
        rd_status(D_WS1, r);
        n_checks++;
        if (r !== 32'h0000_0009) begin n_errors++; $display("FAIL udf_sel_ignored got=%h exp=00000009", r); end
        wr_ctl(D_WS1, 32'h1, 4'b0001);
        rd_status(D_WS1, r);
        n_checks++;
        if (r !== 32'h0000_0001) begin n_errors++; $display("FAIL udf_cleared got=%h exp=00000001", r); end
    endtask

    task automatic test_abort();
        logic [31:0] r; int l; logic seen;
        xfer(D_WS3, 1'b1, ADR_DATA, 4'hF, 32'h0000_00A5, r, l);
        n_checks++;
        if (l !== 4) begin n_errors++; $display("FAIL ws3_latency got=%0d exp=4", l); end
        // Read strobe dropped while waiting: must not ACK or pop.
        seen = 1'b0;
        @(posedge clk); #1;
        we = 1'b0; adr = ADR_DATA; sel = 4'hF; stb[D_WS3] = 1'b1;
        repeat (2) begin @(posedge clk); #1; seen |= bus_ws3.ACK_O; end
        stb[D_WS3] = 1'b0;
        repeat (6) begin @(posedge clk); #1; seen |= bus_ws3.ACK_O; end
        n_checks++;
        if (seen !== 1'b0) begin n_errors++; $display("FAIL abort_ack got=%b exp=0", seen); end
        rd_status(D_WS3, r);
        n_checks++;
        if (r !== 32'h0000_0100) begin n_errors++; $display("FAIL abort_count got=%h exp=00000100", r); end
        // Reset pulsed while a push is waiting.
        seen = 1'b0;
        @(posedge clk); #1;
        we = 1'b1; adr = ADR_DATA; sel = 4'hF; dat = 32'h0000_0BAD; stb[D_WS3] = 1'b1;
        repeat (2) begin @(posedge clk); #1; seen |= bus_ws3.ACK_O; end
        rst = 1'b1;
        stb[D_WS3] = 1'b0;
        #1 seen |= bus_ws3.ACK_O;
        @(posedge clk); #1;
        seen |= bus_ws3.ACK_O;
        rst = 1'b0;
        repeat (6) begin @(posedge clk); #1; seen |= bus_ws3.ACK_O; end
        n_checks++;
        if (seen !== 1'b0) begin n_errors++; $display("FAIL rst_mid_ack got=%b exp=0", seen); end
        rd_status(D_WS3, r);
        n_checks++;
        if (r !== 32'h0000_0001) begin n_errors++; $display("FAIL rst_mid_status got=%h exp=00000001", r); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; logic [5:0] pattern;
        pattern = '0;
        @(posedge clk); #1;
        we = 1'b1; adr = ADR_DATA; sel = 4'hF; dat = 32'h100; stb[D_WS0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            pattern[i] = bus_ws0.ACK_O;
            dat = 32'h100 + 32'(i + 1);
        end
        stb[D_WS0] = 1'b0;
        n_checks++;
        if (pattern !== 6'b010101) begin n_errors++; $display("FAIL b2b_ack_pattern got=%b exp=010101", pattern); end
        rd_status(D_WS0, r);
        n_checks++;
        if (r !== 32'h0000_0300) begin n_errors++; $display("FAIL b2b_count got=%h exp=00000300", r); end
        pop(D_WS0, r);
        n_checks++;
        if (r !== 32'h0000_0100) begin n_errors++; $display("FAIL b2b_pop got=%h exp=00000100", r); end
        n_checks++;
        if (irq_of(D_WS0) !== 1'b1) begin n_errors++; $display("FAIL b2b_irq_high got=%b exp=1", irq_of(D_WS0)); end
        wr_ctl(D_WS0, 32'h2, 4'hF);
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (irq_of(D_WS0) !== 1'b0) begin n_errors++; $display("FAIL b2b_irq_low got=%b exp=0", irq_of(D_WS0)); end
        rd_status(D_WS0, r);
        n_checks++;
        if (r !== 32'h0000_0001) begin n_errors++; $display("FAIL b2b_flush got=%h exp=00000001", r); end
    endtask

    initial begin
        test_reset();
        test_push_pop();
        test_overflow();
        test_underflow();
        test_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
